// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder
//   Bit-serial (nibble-serial) adder/subtractor. One 4-bit add slice is reused
//   for N = WIDTH/4 cycles, LSB nibble first. A+B+Cin when sub=0, A-B (as
//   A+~B+1) when sub=1. Results are registered and held until consumed.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   operand set present          in_ready   idle, can accept
//   A, B       operands (WIDTH bits)        Cin        carry-in (add only)
//   sub        0: A+B+Cin, 1: A-B
//   out_valid  result present               out_ready  consumer accepts result
//   F          sum/difference (mod 2^WIDTH)
//   Cout       carry out of MSB (sub: 1 = no borrow)
//   OF         signed overflow              ZF         F == 0
module nibble_serial_adder #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] F,
    output logic             Cout,
    output logic             OF,
    output logic             ZF
);

    localparam int N  = WIDTH / 4;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] opa, opb;   // opb already holds ~B for subtraction
    logic [3:0]       nib_sum;
    logic             nib_co;
    logic [WIDTH-1:0] f_nxt;
    logic             accept;
    logic             last_step;

    // The single 4-bit add slice.
    function automatic logic [4:0] add_slice(input logic [3:0] a,
                                             input logic [3:0] b,
                                             input logic       ci);
        return {1'b0, a} + {1'b0, b} + {4'b0000, ci};
    endfunction

    assign accept    = (state == IDLE) && in_valid;
    assign last_step = (state == RUN) && (cnt == LAST);

    always_comb begin
        {nib_co, nib_sum} = add_slice(opa[cnt*4 +: 4], opb[cnt*4 +: 4], carry);
        // F with the current nibble merged in; on the last step this is the
        // final result, so the flags can be registered on the same edge.
        f_nxt             = F;
        f_nxt[cnt*4 +: 4] = nib_sum;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state and handshake outputs
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = RUN;
            end
            RUN: begin
                if (cnt == LAST) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                // Consumption returns to IDLE; acceptance cannot share this edge.
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture: data only, no reset needed
    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            opa <= A;
            opb <= sub ? ~B : B;
        end
    end

    // Counter, carry and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            carry <= 1'b0;
            F     <= '0;
            Cout  <= 1'b0;
            OF    <= 1'b0;
            ZF    <= 1'b0;
        end else if (accept) begin
            cnt   <= '0;
            carry <= sub ? 1'b1 : Cin;
        end else if (state == RUN) begin
            F     <= f_nxt;
            carry <= nib_co;
            if (last_step) begin
                Cout <= nib_co;
                // Overflow: operands agree in sign but the result does not.
                OF   <= (opa[WIDTH-1] == opb[WIDTH-1]) &&
                        (f_nxt[WIDTH-1] != opa[WIDTH-1]);
                ZF   <= (f_nxt == '0);
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
module tb_nibble_serial_adder;

    localparam int W = 32;
    localparam int N = W / 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         Cin = 1'b0;
    logic         sub = 1'b0;
    logic         in_ready, out_valid, Cout, OF, ZF;
    logic [W-1:0] F;

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Cin(Cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .F(F), .Cout(Cout), .OF(OF), .ZF(ZF)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Reference arithmetic from plain integer math.
    task automatic model_calc(input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic ci, input logic s,
                              output logic [W-1:0] f, output logic c,
                              output logic o, output logic z);
        logic [W:0] u;
        longint     r;
        if (!s) begin
            u = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
            f = u[W-1:0];
            c = u[W];
            r = longint'($signed(a)) + longint'($signed(b)) + longint'(ci);
        end else begin
            f = a - b;
            c = (a >= b);
            r = longint'($signed(a)) - longint'($signed(b));
        end
        o = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        z = (f == '0);
    endtask

    logic         m_pend = 1'b0;
    int           m_acc = 0;
    int           cyc = 0;
    logic [W-1:0] m_F = '0;
    logic         m_C = 1'b0, m_OF = 1'b0, m_ZF = 1'b0;
    logic         armed = 1'b0;

    always @(posedge clk) begin : model
        logic [W-1:0] f;
        logic         c, o, z;
        if (rst) begin
            m_pend <= 1'b0;
            m_F    <= '0;
            m_C    <= 1'b0;
            m_OF   <= 1'b0;
            m_ZF   <= 1'b0;
            armed  <= 1'b1;
        end else if (!m_pend && in_valid) begin
            model_calc(A, B, Cin, sub, f, c, o, z);
            m_F    <= f;
            m_C    <= c;
            m_OF   <= o;
            m_ZF   <= z;
            m_pend <= 1'b1;
            m_acc  <= cyc;
        end else if (m_pend && (cyc > m_acc + N) && out_ready) begin
            m_pend <= 1'b0;
        end
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin : compare
        logic done_m;
        if (armed) begin
            done_m = m_pend && (cyc > m_acc + N);
            chk("in_ready", {31'b0, in_ready}, {31'b0, !m_pend});
            chk("out_valid", {31'b0, out_valid}, {31'b0, done_m});
            if (done_m || !m_pend) begin
                chk("F", F, m_F);
                chk("Cout", {31'b0, Cout}, {31'b0, m_C});
                chk("OF", {31'b0, OF}, {31'b0, m_OF});
                chk("ZF", {31'b0, ZF}, {31'b0, m_ZF});
            end
        end
    end

    // Issue one operation from a negedge; returns at the negedge on which
    // out_valid is first seen (or after consuming it when cons=1).
    task automatic run_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ci, input logic s, input logic [W-1:0] ef,
                          input logic ec, input logic eo, input logic ez, input bit cons);
        int t;
        int lat;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        A = a; B = b; Cin = ci; sub = s; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        A = ~a; B = $urandom; Cin = ~ci; sub = ~s;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, " latency"}, lat, N);
        chk({nm, " F"}, F, ef);
        chk({nm, " Cout"}, {31'b0, Cout}, {31'b0, ec});
        chk({nm, " OF"}, {31'b0, OF}, {31'b0, eo});
        chk({nm, " ZF"}, {31'b0, ZF}, {31'b0, ez});
        if (cons) begin
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset in_ready", {31'b0, in_ready}, 32'd1);
        chk("reset out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset F", F, 32'h0);
        chk("reset flags", {29'b0, Cout, OF, ZF}, 32'd0);

        run_op("add wrap", 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b1);
        run_op("add ovf", 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1);
        run_op("sub 5-7", 32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b1);
        run_op("sub 7-5 c0", 32'd7, 32'd5, 1'b0, 1'b1, 32'h00000002, 1'b1, 1'b0, 1'b0, 1'b1);
        run_op("sub 7-5 c1", 32'd7, 32'd5, 1'b1, 1'b1, 32'h00000002, 1'b1, 1'b0, 1'b0, 1'b1);

        // Hold the result while the consumer stalls and inputs churn.
        run_op("hold", 32'h0F0F0F0F, 32'h01010101, 1'b1, 1'b0, 32'h10101011, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (5) begin
            @(negedge clk);
            in_valid = ~in_valid;
            A = $urandom;
            B = $urandom;
        end
        in_valid = 1'b0;
        chk("hold F", F, 32'h10101011);
        chk("hold out_valid", {31'b0, out_valid}, 32'd1);
        chk("hold in_ready", {31'b0, in_ready}, 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("release in_ready", {31'b0, in_ready}, 32'd1);
        chk("release out_valid", {31'b0, out_valid}, 32'd0);
        run_op("b2b sub", 32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b1);

        // Abort mid-RUN at count 3.
        A = 32'h12345678; B = 32'h11111111; Cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort in_ready", {31'b0, in_ready}, 32'd1);
        chk("abort out_valid", {31'b0, out_valid}, 32'd0);
        chk("abort F", F, 32'h0);
        chk("abort flags", {29'b0, Cout, OF, ZF}, 32'd0);
        repeat (12) @(negedge clk);
        chk("abort no result", {31'b0, out_valid}, 32'd0);
        run_op("after abort", 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b1);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand/result width in bits; legal values are multiples of 4 that are 8 or greater.
REQ-002 SHALL define derived constant N = WIDTH/4: number of nibble steps per operation.
REQ-003 clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  operand set is present.
REQ-006 in_ready  output  1  block can accept an operand set.
REQ-007 A  input  WIDTH  operand A.
REQ-008 B  input  WIDTH  operand B.
REQ-009 Cin  input  1  carry-in; used only when sub=0.
REQ-010 sub  input  1  0 selects A+B+Cin; 1 selects A-B (computed as A+~B+1).
REQ-011 out_valid  output  1  result is present.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 F  output  WIDTH  sum/difference.
REQ-014 Cout  output  1  carry out of the MSB; for sub, 1 means no borrow.
REQ-015 OF  output  1  signed overflow.
REQ-016 ZF  output  1  F equals zero.

Function
REQ-017 SHALL contain exactly one 4-bit add slice and process one nibble per RUN cycle, LSB nibble first.
REQ-018 SHALL implement states IDLE, RUN and DONE.
REQ-019 SHALL drive in_ready=1 only in IDLE; SHALL drive out_valid=1 only in DONE.
REQ-020 SHALL accept an operand set on the rising edge where in_valid and in_ready are both 1, with these effects:
- capture A, B (or ~B when sub=1) and the sign bits needed for OF;
- set the carry register to Cin (sub=0) or 1 (sub=1);
- clear the nibble counter;
- go to RUN.
REQ-021 SHALL ignore A, B, Cin, sub and in_valid outside the acceptance edge.
REQ-022 In RUN, at count k, SHALL apply these effects:
- write slice sum into F[4k+3:4k];
- load the carry register with the slice carry-out;
- increment the counter.
REQ-023 At count N-1, SHALL go to DONE instead of incrementing.
REQ-024 SHALL present out_valid=1 exactly N cycles after the acceptance edge; for WIDTH=32 this is 8 cycles.
REQ-025 In DONE, SHALL drive Cout from the carry register and hold it.
REQ-026 In DONE, SHALL drive OF = (opA[MSB] == opB_eff[MSB]) and (F[MSB] != opA[MSB]).
REQ-027 In DONE, SHALL drive ZF = (F == 0).
REQ-028 SHALL keep F, Cout, OF and ZF as registered outputs, stable for as long as out_valid=1.
REQ-029 SHALL hold DONE and all results while out_ready=0, with no timeout.
REQ-030 On the edge where out_valid and out_ready are both 1, SHALL return to IDLE.
REQ-031 SHALL keep F, Cout, OF and ZF unchanged in IDLE until the next operation's first RUN write.
REQ-032 SHALL NOT accept a new operand set on the same edge a result is consumed; in_ready rises the cycle after, so minimum issue interval is N+2 cycles.
REQ-033 SHALL let the carry out of the MSB nibble wrap only into Cout; F is modulo 2^WIDTH.
REQ-034 SHALL ignore in_valid=1 during RUN and DONE; it never corrupts the operation in flight.

Reset
REQ-035 When rst=1 at a rising edge, SHALL take the following values in the next cycle, regardless of state, including mid-RUN:
- state = IDLE;
- in_ready=1, out_valid=0;
- F=0, Cout=0, OF=0, ZF=0;
- counter and carry register = 0.
REQ-036 rst SHALL take priority over acceptance and consumption on the same edge.
REQ-037 SHALL discard any partial result on reset and produce no out_valid for the aborted operation.

Verification (WIDTH=32)
REQ-038 A=0x00000001, B=0xFFFFFFFF, Cin=0, sub=0 -> 8 cycles after acceptance: out_valid=1, F=0x00000000, Cout=1, ZF=1, OF=0.
REQ-039 A=0x7FFFFFFF, B=0x00000001, Cin=0, sub=0 -> F=0x80000000, Cout=0, OF=1, ZF=0.
REQ-040 sub=1 cases:
- A=5, B=7 -> F=0xFFFFFFFE, Cout=0, OF=0;
- then A=7, B=5, with Cin=0 and Cin=1 -> F=0x00000002, Cout=1 in both (Cin ignored).
REQ-041 Hold out_ready=0 for 5 cycles after out_valid rises, toggling in_valid/A/B meanwhile -> out_valid, F and flags are unchanged and in_ready=0; raise out_ready -> IDLE next cycle, and a back-to-back operation gives the correct new result.
REQ-042 Assert rst for one cycle at RUN count 3 -> next cycle in_ready=1, out_valid=0, F=0; a following A=0xFFFFFFFF, B=0, Cin=1 gives F=0, Cout=1, ZF=1.
